// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the MIPS multicycle and single-cycle controllers.
// State codes, opcode/funct values and datapath select encodings.
package mips_mc_controller_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_EXEC    = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_BRANCH  = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JUMP    = 4'd11;
    localparam state_t S_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_aludec.sv
// R-type funct decoder: ALU operation plus a legality flag.
// Purely combinational; shared with the single-cycle controller.
module mips_aludec
    import mips_mc_controller_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] funct,
    output logic [2:0]      alucontrol,
    output logic            funct_legal
);

    always_comb begin
        alucontrol  = ALU_ADD;
        funct_legal = 1'b1;
        unique case (funct)
            F_ADD:   alucontrol = ALU_ADD;
            F_SUB:   alucontrol = ALU_SUB;
            F_AND:   alucontrol = ALU_AND;
            F_OR:    alucontrol = ALU_OR;
            F_SLT:   alucontrol = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: one micro-step per clock, Moore outputs
// gated by mem_ready only for the memory-completing strobes.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
#(
    parameter int OP_W         = 6,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_W-1:0]         op,
    input  logic [OP_W-1:0]         funct,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    memwrite,
    output logic                    iord,
    output logic                    irwrite,
    output logic                    pcen,
    output logic                    regwrite,
    output logic                    regdst,
    output logic                    memtoreg,
    output logic                    alusrca,
    output logic [1:0]              alusrcb,
    output logic [1:0]              pcsrc,
    output logic [2:0]              alucontrol,
    output logic                    illegal,
    output logic [RETIRE_CNT_W-1:0] retired
);

    state_t                  state_q, state_d;
    logic [RETIRE_CNT_W-1:0] retired_q, retired_d;
    logic [2:0]              funct_alu;
    logic                    funct_legal;
    logic                    pcwrite;
    logic                    branch;
    logic                    retire;

    mips_aludec #(.OP_W(OP_W)) u_aludec (
        .funct       (funct),
        .alucontrol  (funct_alu),
        .funct_legal (funct_legal)
    );

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        alucontrol = ALU_AND;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb    = SRCB_IMMSH;
                alucontrol = ALU_ADD;
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? S_EXEC : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        pcen   = pcwrite | (branch & zero);
        // ILLEGAL -> FETCH is a skip, not a completion
        retire = (state_d == S_FETCH) && (state_q != S_FETCH)
              && (state_q != S_ILLEGAL);

        if (reset) begin
            state_d  = S_FETCH;
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end

        retired_d = reset ? '0 : retired_q + RETIRE_CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        retired_q <= retired_d;
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed + randomized bench for the multicycle controller, checked
// against an instruction-level model of the expected micro-step trace.
module tb_mips_mc_controller;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          mem_req;
    logic          memwrite;
    logic          iord;
    logic          irwrite;
    logic          pcen;
    logic          regwrite;
    logic          regdst;
    logic          memtoreg;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [1:0]    pcsrc;
    logic [2:0]    alucontrol;
    logic          illegal;
    logic [RW-1:0] retired;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] exp_ret = '0;
    bit            ret_known = 1'b0;

    always #5 clk = ~clk;

    mips_mc_controller #(.OP_W(6), .RETIRE_CNT_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .retired    (retired)
    );

    // Bit order: mem_req memwrite iord irwrite pcen regwrite regdst
    // memtoreg alusrca alusrcb pcsrc alucontrol illegal
    function automatic logic [16:0] ev(
        input logic mq, mw, io, irw, pce, rw, rd, m2r, sa,
        input logic [1:0] sb, ps, input logic [2:0] ac, input logic ill);
        return {mq, mw, io, irw, pce, rw, rd, m2r, sa, sb, ps, ac, ill};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100
            || f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic cyc(input string tag, input logic rst, input logic mr,
                       input logic z, input logic [16:0] exp);
        logic [16:0] obs;
        logic [16:0] m;
        @(negedge clk);
        reset = rst;
        mem_ready = mr;
        zero = z;
        #1;
        obs = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
               memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal};
        // Under reset only enables and illegal are defined
        m = rst ? 17'h1B801 : 17'h1FFFF;
        checks++;
        assert ((obs & m) === (exp & m)) else begin
            errors++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs & m, exp & m);
        end
        if (ret_known) begin
            checks++;
            assert (retired === exp_ret) else begin
                errors++;
                $error("FAIL %s retired observed=%0d expected=%0d",
                       tag, retired, exp_ret);
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_ret = '0;
            ret_known = 1'b1;
        end
    endtask

    task automatic fetch_decode(input string tag, input int fw);
        repeat (fw) cyc({tag, ":fetchw"}, 0, 0, rb(),
            ev(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
        cyc({tag, ":fetch"}, 0, 1, rb(),
            ev(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0));
        cyc({tag, ":decode"}, 0, rb(), rb(),
            ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op_i,
                             input logic [5:0] f_i, input logic z_i,
                             input int fw, input int mw);
        op = op_i;
        funct = f_i;
        fetch_decode(tag, fw);
        if (op_i == 6'b100011 || op_i == 6'b101011) begin
            cyc({tag, ":memadr"}, 0, rb(), rb(),
                ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
            if (op_i == 6'b100011) begin
                repeat (mw) cyc({tag, ":memrdw"}, 0, 0, rb(),
                    ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
                cyc({tag, ":memrd"}, 0, 1, rb(),
                    ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
                cyc({tag, ":memwb"}, 0, rb(), rb(),
                    ev(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0));
            end else begin
                repeat (mw) cyc({tag, ":memwrw"}, 0, 0, rb(),
                    ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
                cyc({tag, ":memwr"}, 0, 1, rb(),
                    ev(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
            end
            exp_ret = exp_ret + 1'b1;
        end else if (op_i == 6'b000000 && funct_ok(f_i)) begin
            cyc({tag, ":exec"}, 0, rb(), rb(),
                ev(0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu_of(f_i),0));
            cyc({tag, ":aluwb"}, 0, rb(), rb(),
                ev(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,0));
            exp_ret = exp_ret + 1'b1;
        end else if (op_i == 6'b000100) begin
            cyc({tag, ":branch"}, 0, rb(), z_i,
                ev(0,0,0,0,z_i,0,0,0,1,2'b00,2'b01,3'b110,0));
            exp_ret = exp_ret + 1'b1;
        end else if (op_i == 6'b001000) begin
            cyc({tag, ":addiex"}, 0, rb(), rb(),
                ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
            cyc({tag, ":addiwb"}, 0, rb(), rb(),
                ev(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0));
            exp_ret = exp_ret + 1'b1;
        end else if (op_i == 6'b000010) begin
            cyc({tag, ":jump"}, 0, rb(), rb(),
                ev(0,0,0,0,1,0,0,0,0,2'b00,2'b10,3'b000,0));
            exp_ret = exp_ret + 1'b1;
        end else begin
            cyc({tag, ":illegal"}, 0, rb(), rb(),
                ev(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] rop;
        logic [5:0] rf;
        int         k;
        reset = 1'b1;
        mem_ready = 1'b1;
        op = '0;
        funct = '0;
        zero = 1'b0;

        repeat (3) cyc("reset", 1, 1, 0, '0);

        run_instr("lw", 6'b100011, 6'b000000, 0, 0, 0);
        run_instr("sw_wait2", 6'b101011, 6'b000000, 0, 0, 2);
        run_instr("beq_t", 6'b000100, 6'b000000, 1, 0, 0);
        run_instr("beq_nt", 6'b000100, 6'b000000, 0, 0, 0);
        run_instr("slt", 6'b000000, 6'b101010, 0, 0, 0);
        run_instr("bad_funct", 6'b000000, 6'b000111, 0, 0, 0);
        run_instr("addi", 6'b001000, 6'b010101, 0, 1, 0);
        run_instr("j", 6'b000010, 6'b111111, 0, 0, 0);
        run_instr("lw_wait", 6'b100011, 6'b000000, 0, 2, 3);

        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 7));
            rf = 6'($urandom);
            case (k)
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: begin
                    rop = 6'b000000;
                    case ($urandom_range(0, 4))
                        0: rf = 6'b100000;
                        1: rf = 6'b100010;
                        2: rf = 6'b100100;
                        3: rf = 6'b100101;
                        default: rf = 6'b101010;
                    endcase
                end
                3: rop = 6'b000100;
                4: rop = 6'b001000;
                5: rop = 6'b000010;
                6: rop = 6'b000000;
                default: rop = 6'($urandom);
            endcase
            run_instr("rand", rop, rf, rb(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        op = 6'b100011;
        funct = '0;
        fetch_decode("rst_lw", 0);
        cyc("rst_lw:memadr", 0, 1, 0,
            ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
        cyc("rst_lw:memrdw", 0, 0, 0,
            ev(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0));
        cyc("rst_memrd", 1, 1, 0, '0);
        run_instr("after_rst", 6'b001000, 6'b000000, 0, 0, 0);
        run_instr("after_rst2", 6'b000010, 6'b000000, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle control FSM that sequences the MIPS datapath (PC register, register file, ALU, shared instruction/data memory) one micro-step per clock. It decodes opcode/funct from the instruction register and drives all datapath selects and write enables. It also handshakes with a variable-latency unified memory. Executes lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- OP_W, 6, opcode/funct field width
- RETIRE_CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access in progress
- memwrite  out  1  store strobe, qualified by mem_ready
- iord  out  1  0 = address from PC, 1 = from ALUOut
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = data register
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse on undecodable instruction
- retired  out  RETIRE_CNT_W  count of completed instructions

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL. Registered state; outputs are a Moore decode of state, gated only by mem_ready where noted.
- Reset (synchronous): state <= FETCH, retired <= 0. All enables (pcen, irwrite, regwrite, memwrite, mem_req) and illegal are forced 0 while reset is high. Reset mid-instruction abandons it; no partial write follows.
- Selects not listed for a state are don't-care. The implementation drives them to 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. Hold while mem_ready=0. In the cycle mem_ready=1: irwrite=1, pcen=1, next DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target to ALUOut). Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 with legal funct -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else, including R-type with an unknown funct -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Next FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Hold until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, so pcen=zero. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next FETCH.
- JUMP: pcsrc=10, pcen=1. Next FETCH.
- ILLEGAL: illegal=1 for exactly one cycle; no architectural write. Next FETCH; PC was already advanced, so the instruction is skipped.
- retired increments by 1 on every transition into FETCH from a non-FETCH, non-ILLEGAL state. It wraps modulo 2^RETIRE_CNT_W.
- Latency with zero-wait memory (mem_ready tied 1): lw 5 cycles; sw, R-type, addi 4; beq, j 3. Each memory wait cycle adds 1.
- mem_ready asserted outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Shared package: state enum, opcode and funct constants, alucontrol codes, alusrcb/pcsrc encodings.
- One sub-module: mips_aludec (funct -> alucontrol plus funct_legal), purely combinational, reused by the single-cycle controller.

Test Plan:
- Reset 3 cycles, mem_ready=1 → during reset all enables 0, retired=0. First post-reset cycle is FETCH with irwrite=1, pcen=1.
- lw (op=100011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with memtoreg=1 in cycle 5 only; retired 0->1.
- sw with mem_ready low for 2 cycles in MEMWR → mem_req held 3 cycles, memwrite=1 only in the mem_ready cycle, sw total 6 cycles.
- beq, zero=1 → pcen=1 in BRANCH with pcsrc=01. Repeat with zero=0 → pcen=0, 3 cycles each.
- R-type funct=101010 → alucontrol=111 in EXEC, regdst=1 in ALUWB. funct=000111 → ILLEGAL, illegal pulse width 1, regwrite never asserted.
- Reset asserted in MEMRD → next cycle FETCH, no regwrite; retired unchanged from the pre-reset value or cleared to 0 (cleared, per reset rule).
